hash_out_buf: RTL and testbench
===============================

Name: hash_out_buf

Overview:
- Byte buffer directly downstream of blake2s_hash256.
- Captures the digest byte stream (h_v/h) into a 32-byte store and replays it to the IO interface over a valid/ready handshake.
- Cut-through: output may start before the digest is complete. Truncates output to nn bytes.
- Decouples the core's fixed-rate digest emission from a host that may stall.

Parameters:
- DEPTH, 32, maximum digest bytes stored (BLAKE2s max nn).
- W, 8, byte width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- nn_i  input  6  digest length in bytes; sampled with first accepted byte
- h_v_i  input  1  digest byte valid from core
- h_i  input  W  digest byte from core, byte 0 first
- wr_ready_o  output  1  high in IDLE only; buffer can accept a new digest
- out_v_o  output  1  output byte valid
- out_o  output  W  output byte; 0 when out_v_o low
- out_ready_i  input  1  consumer accepts byte when out_v_o & out_ready_i
- out_last_o  output  1  high with final byte (index nn-1) while out_v_o
- done_o  output  1  one-cycle pulse the cycle after the last byte handshake
- err_o  output  1  sticky overflow/protocol error flag

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, wr_cnt=0, rd_cnt=0, len=0, wr_ready_o=1, out_v_o=0, out_o=0, out_last_o=0, done_o=0, err_o=0. Memory contents are not reset.
- Length rule: len = (nn_i==0 || nn_i>32) ? 32 : nn_i. Latched on the first accepted byte. Changes to nn_i after that are ignored.
- State IDLE:
  - wr_ready_o=1.
  - h_v_i: write mem[0]=h_i, latch len, wr_cnt=1.
  - Then go to FILL if len>1, else DRAIN.
- State FILL:
  - Each h_v_i writes mem[wr_cnt] and increments wr_cnt.
  - When the write makes wr_cnt==len, go to DRAIN.
  - Cycles with h_v_i low are legal gaps.
- State DRAIN:
  - No writes.
  - h_v_i here sets err_o and the byte is dropped.
- Read side (FILL and DRAIN):
  - out_v_o = (rd_cnt < wr_cnt), registered.
  - out_o = mem[rd_cnt].
  - A byte written at cycle t is first presentable at t+1; no same-cycle bypass.
  - On handshake, rd_cnt increments.
  - out_o and out_last_o hold stable while out_v_o & !out_ready_i.
  - out_last_o = out_v_o & (rd_cnt == len-1).
- Completion:
  - Handshake of byte len-1 (in DRAIN, or in FILL in the same cycle the last byte is written is impossible because of the 1-cycle latency) causes: next cycle done_o=1, state=IDLE, wr_cnt=rd_cnt=0, out_v_o=0.
  - wr_ready_o rises in that same cycle.
- Simultaneous events:
  - A write and a read handshake in the same FILL cycle are both performed.
  - h_v_i in the done cycle (already IDLE) starts a new digest normally.
- Overflow: the core never emits more than len bytes. Any h_v_i outside IDLE/FILL sets err_o, which clears only on reset.
- Reset mid-operation: abandons the digest. Outputs return to reset values on the next edge and no done_o is produced.
- Counters are 6 bits wide; they never wrap because len≤32.

Test Plan:
- nn=32, out_ready_i=1 constant, core sends bytes 0x00..0x1F back-to-back:
  - out_o = 0x00..0x1F on 32 consecutive cycles, starting 1 cycle after the first write.
  - out_last_o with 0x1F; done_o one cycle later; wr_ready_o=1.
- nn=32, out_ready_i toggling 1/0 every cycle:
  - All 32 bytes delivered in order, no duplicates.
  - out_o stable during stalls; done_o pulses exactly once.
- nn=1, h=0xA5:
  - Direct IDLE→DRAIN.
  - Single out_o=0xA5 with out_last_o=1; done_o follows.
- nn_i=0 then nn_i=40 on separate digests:
  - Both behave as len=32; nn_i changed mid-digest to 4 has no effect.
- nn=4, core sends a 5th byte in DRAIN:
  - err_o=1 and stays high.
  - Only 4 bytes are output and the 5th is dropped.
- nn=16, reset asserted after 8 bytes read:
  - Next cycle out_v_o=0, wr_ready_o=1, no done_o.
  - A fresh nn=2 digest then outputs exactly 2 bytes.

Source files
------------

// File: rtl/hash_out_buf_if.sv
// Digest-byte capture and replay bus between the hash core, the output buffer and the host.
interface hash_out_buf_if #(
  parameter int unsigned W = 8
);
  logic [5:0]   nn_i;
  logic         h_v_i;
  logic [W-1:0] h_i;
  logic         wr_ready_o;
  logic         out_v_o;
  logic [W-1:0] out_o;
  logic         out_ready_i;
  logic         out_last_o;
  logic         done_o;
  logic         err_o;

  // Buffer side.
  modport slave (
    input  nn_i, h_v_i, h_i, out_ready_i,
    output wr_ready_o, out_v_o, out_o, out_last_o, done_o, err_o
  );

  // Core/host side.
  modport master (
    output nn_i, h_v_i, h_i, out_ready_i,
    input  wr_ready_o, out_v_o, out_o, out_last_o, done_o, err_o
  );
endinterface

// File: rtl/hash_out_buf.sv
// Cut-through digest byte buffer: stores up to DEPTH bytes from the hash core
// and replays the first len of them over a valid/ready handshake.
module hash_out_buf #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned W     = 8
) (
  input  logic          clk,
  input  logic          reset,
  hash_out_buf_if.slave bus
);

  localparam int unsigned CW = 6;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] MAX_LEN = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]  len_q, len_d;
  logic [CW-1:0]  len_new_c;
  logic [W-1:0]   mem_q [DEPTH];

  logic           wr_en_c;
  logic           hs_c;
  logic           last_hs_c;
  logic [W-1:0]   rd_data_c;

  logic           wr_ready_q, wr_ready_d;
  logic           out_v_q, out_v_d;
  logic [W-1:0]   out_q, out_d;
  logic           out_last_q, out_last_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  // Effective digest length: 0 or anything above the store size means full size.
  always_comb begin
    len_new_c = bus.nn_i;
    if (bus.nn_i == '0 || bus.nn_i > MAX_LEN) begin
      len_new_c = MAX_LEN;
    end
  end

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    len_d    = len_q;
    err_d    = err_q;

    // Bytes are only stored in IDLE (first byte) and FILL; DRAIN drops them.
    wr_en_c   = bus.h_v_i && (state_q != DRAIN);
    hs_c      = out_v_q && bus.out_ready_i;
    last_hs_c = hs_c && (rd_cnt_q == len_q - ONE);

    if (wr_en_c) begin
      wr_cnt_d = wr_cnt_q + ONE;
    end
    if (hs_c) begin
      rd_cnt_d = rd_cnt_q + ONE;
    end

    case (state_q)
      IDLE: begin
        if (bus.h_v_i) begin
          len_d   = len_new_c;
          state_d = (len_new_c > ONE) ? FILL : DRAIN;
        end
      end
      FILL: begin
        if (wr_en_c && (wr_cnt_d == len_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.h_v_i) begin
          err_d = 1'b1;
        end
        // The final handshake can only occur here: the last byte is
        // presentable one cycle after it is written, i.e. after FILL ends.
        if (last_hs_c) begin
          state_d  = IDLE;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        wr_cnt_d = '0;
        rd_cnt_d = '0;
      end
    endcase

    // Forward the byte being written this cycle into the output register when
    // it is the next one to present, since mem_q only holds it after the edge.
    if (wr_en_c && (rd_cnt_d == wr_cnt_q)) begin
      rd_data_c = bus.h_i;
    end else begin
      rd_data_c = mem_q[rd_cnt_d[AW-1:0]];
    end

    out_v_d    = (rd_cnt_d < wr_cnt_d);
    out_d      = out_v_d ? rd_data_c : '0;
    out_last_d = out_v_d && (rd_cnt_d == len_d - ONE);
    done_d     = last_hs_c;
    wr_ready_d = (state_d == IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      len_q      <= '0;
      wr_ready_q <= 1'b1;
      out_v_q    <= 1'b0;
      out_q      <= '0;
      out_last_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      len_q      <= len_d;
      wr_ready_q <= wr_ready_d;
      out_v_q    <= out_v_d;
      out_q      <= out_d;
      out_last_q <= out_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Byte store; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_c) begin
      mem_q[wr_cnt_q[AW-1:0]] <= bus.h_i;
    end
  end

  assign bus.wr_ready_o = wr_ready_q;
  assign bus.out_v_o    = out_v_q;
  assign bus.out_o      = out_q;
  assign bus.out_last_o = out_last_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_hash_out_buf.sv
// Bench for hash_out_buf: directed digests with randomized data, gaps and
// back-pressure, compared cycle by cycle against a transaction-level model.
module tb_hash_out_buf;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  hash_out_buf_if #(.W(8)) bus ();

  hash_out_buf #(.DEPTH(32), .W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Model: bytes accepted for the current digest and how many were consumed.
  logic [7:0] m_bytes [32];
  int         m_len;
  int         m_wr;
  int         m_rd;
  bit         m_idle;
  bit         m_done;
  bit         m_err;

  int         obs_done = 0;
  int         obs_hs   = 0;
  longint     last_chk_t = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int len_of(input int nn);
    return (nn == 0 || nn > 32) ? 32 : nn;
  endfunction

  task automatic model_reset();
    m_len  = 0;
    m_wr   = 0;
    m_rd   = 0;
    m_idle = 1'b1;
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  // Compare every DUT output with the model for the current cycle.
  task automatic check_outputs();
    bit v;
    v = !m_idle && (m_rd < m_wr);
    chk("out_v", 32'(bus.out_v_o), 32'(v));
    chk("out", 32'(bus.out_o), v ? 32'(m_bytes[m_rd]) : 32'd0);
    chk("out_last", 32'(bus.out_last_o), 32'(v && (m_rd == m_len - 1)));
    chk("done", 32'(bus.done_o), 32'(m_done));
    chk("wr_ready", 32'(bus.wr_ready_o), 32'(m_idle));
    chk("err", 32'(bus.err_o), 32'(m_err));
    if (longint'($time) != last_chk_t && bus.done_o === 1'b1) obs_done++;
    last_chk_t = longint'($time);
  endtask

  // Drive one cycle of inputs, advance the model, then move past the edge.
  task automatic step(input bit hv, input logic [7:0] h, input logic [5:0] nn, input bit rdy);
    bit v;
    bit hs;
    bit last;
    bus.h_v_i       = hv;
    bus.h_i         = h;
    bus.nn_i        = nn;
    bus.out_ready_i = rdy;
    v    = !m_idle && (m_rd < m_wr);
    hs   = v && rdy;
    last = hs && (m_rd == m_len - 1);
    if (bus.out_v_o === 1'b1 && rdy) obs_hs++;
    m_done = 1'b0;
    if (m_idle) begin
      if (hv) begin
        m_len      = len_of(int'(nn));
        m_bytes[0] = h;
        m_wr       = 1;
        m_rd       = 0;
        m_idle     = 1'b0;
      end
    end else begin
      if (hv) begin
        if (m_wr < m_len) begin
          m_bytes[m_wr] = h;
          m_wr++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (hs) begin
        m_rd++;
        if (last) begin
          m_idle = 1'b1;
          m_wr   = 0;
          m_rd   = 0;
          m_done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check_outputs();
      step(1'b0, 8'h00, 6'd0, 1'($urandom_range(1)));
    end
  endtask

  // One digest: nn_first with the first byte, nn_later afterwards; n_send bytes
  // from the core; seq selects base+index data, else random; rdy_mode 0=always,
  // 1=toggle, 2=random; abort_at>0 resets once that many bytes are consumed.
  task automatic run_digest(input int nn_first, input int nn_later, input int n_send,
                            input bit seq, input int base, input int gap_pct,
                            input int rdy_mode, input int abort_at);
    int         sent;
    bit         started;
    bit         finished;
    int         d0;
    int         h0;
    int         len_exp;
    bit         hv;
    bit         rdy;
    logic [7:0] h;
    logic [5:0] nn;
    sent     = 0;
    started  = 1'b0;
    finished = 1'b0;
    d0       = obs_done;
    h0       = obs_hs;
    len_exp  = len_of(nn_first);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check_outputs();
      if (started && m_idle) begin
        finished = 1'b1;
        break;
      end
      if (abort_at > 0 && m_rd == abort_at) begin
        bus.h_v_i       = 1'b0;
        bus.out_ready_i = 1'b0;
        reset           = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_outputs();
        chk("abort_no_done", 32'(obs_done - d0), 32'd0);
        return;
      end
      hv = (sent < n_send) && ($urandom_range(99) >= gap_pct);
      h  = seq ? 8'(base + sent) : 8'($urandom);
      nn = started ? 6'(nn_later) : 6'(nn_first);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 0;
        default: rdy = 1'($urandom_range(1));
      endcase
      if (hv) begin
        sent++;
        started = 1'b1;
      end
      step(hv, h, nn, rdy);
    end
    cmp_cnt++;
    assert (finished) else begin
      err_cnt++;
      $error("FAIL digest_timeout: nn=%0d observed=unfinished expected=finished", nn_first);
    end
    chk("done_pulses", 32'(obs_done - d0), 32'd1);
    chk("bytes_out", 32'(obs_hs - h0), 32'(len_exp));
  endtask

  initial begin
    int nn;
    bus.h_v_i       = 1'b0;
    bus.h_i         = 8'h00;
    bus.nn_i        = 6'd0;
    bus.out_ready_i = 1'b0;
    reset           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_outputs();

    // Full digest 0x00..0x1F, no back-pressure.
    run_digest(32, 32, 32, 1'b1, 0, 0, 0, 0);
    idle_cycles(2);
    // Full digest with ready toggling every cycle.
    run_digest(32, 32, 32, 1'b0, 0, 0, 1, 0);
    // Single byte, started in the done cycle of the previous digest.
    run_digest(1, 1, 1, 1'b1, 8'hA5, 0, 0, 0);
    idle_cycles(1);
    // nn=0 and nn=40 both mean 32; nn changed to 4 mid-digest is ignored.
    run_digest(0, 4, 32, 1'b0, 0, 20, 2, 0);
    run_digest(40, 4, 32, 1'b0, 0, 20, 2, 0);
    // Overflow: fifth byte while draining sets sticky err and is dropped.
    run_digest(4, 4, 5, 1'b0, 0, 0, 0, 0);
    idle_cycles(3);
    run_digest(9, 20, 9, 1'b0, 0, 30, 2, 0);
    // Reset after 8 of 16 bytes read, then a fresh 2-byte digest.
    run_digest(16, 16, 16, 1'b0, 0, 0, 0, 8);
    idle_cycles(2);
    run_digest(2, 2, 2, 1'b0, 0, 0, 0, 0);
    // Random lengths, gaps and back-pressure.
    for (int i = 0; i < 6; i++) begin
      nn = int'($urandom_range(63));
      run_digest(nn, int'($urandom_range(63)), len_of(nn), 1'b0, 0,
                 int'($urandom_range(50)), int'($urandom_range(2)), 0);
      if ($urandom_range(1) == 1) idle_cycles(int'($urandom_range(3)));
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
